// File: rtl/rom_read_arbiter_pkg.sv
// rtl/rom_read_arbiter_pkg.sv - shared widths, state encodings and requester ids
package rom_read_arbiter_pkg;

    localparam int AW = 4;
    localparam int DW = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_read_arbiter_if.sv
// rtl/rom_read_arbiter_if.sv - requester, ROM and read-return signal bundle
interface rom_read_arbiter_if
    import rom_read_arbiter_pkg::*;
();
    logic          req0;
    logic [AW-1:0] addr0;
    logic [AW-1:0] len0;
    logic          gnt0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [AW-1:0] len1;
    logic          gnt1;
    logic          rom_cs;
    logic          rom_read_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_id;
    logic          rd_last;
    logic          busy;

    modport master (
        output req0, addr0, len0, req1, addr1, len1, rom_data,
        input  gnt0, gnt1, rom_cs, rom_read_en, rom_addr,
               rd_data, rd_valid, rd_id, rd_last, busy
    );

    modport slave (
        input  req0, addr0, len0, req1, addr1, len1, rom_data,
        output gnt0, gnt1, rom_cs, rom_read_en, rom_addr,
               rd_data, rd_valid, rd_id, rd_last, busy
    );
endinterface

// File: rtl/rom_read_arbiter_rom.sv
// rtl/rom_read_arbiter_rom.sv - 16x8 combinational ROM image
module ROM_16x8 (
    input  logic       cs,
    input  logic       read_en,
    input  logic [3:0] addrb,
    output logic [7:0] datab
);

    // Unlisted words read as zero; the port is quiet unless selected.
    always_comb begin
        datab = 8'd0;
        if (cs && read_en) begin
            case (addrb)
                4'd0:    datab = 8'd21;
                4'd6:    datab = 8'd10;
                4'd7:    datab = 8'd88;
                4'd8:    datab = 8'd28;
                4'd9:    datab = 8'd38;
                4'd14:   datab = 8'd88;
                4'd15:   datab = 8'd98;
                default: datab = 8'd0;
            endcase
        end
    end

endmodule

// File: rtl/rom_read_arbiter_rr_arb2.sv
// rtl/rom_read_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] win_o
);

    // Lone requester always wins; on a tie the pointer names the winner.
    always_comb begin
        win_o    = 2'b00;
        win_o[0] = req_i[0] & (~req_i[1] | ~prio_i);
        win_o[1] = req_i[1] & (~req_i[0] |  prio_i);
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin burst sequencer sharing one ROM
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    rom_read_arbiter_if.slave  bus
);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d;
    // The ROM address register doubles as the burst's current address.
    logic [AW-1:0] addr_q, addr_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          cs_q, cs_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_id_q, rd_id_d;
    logic          rd_last_q, rd_last_d;
    logic [1:0]    win;

    rr_arb2 u_arb (
        .req_i  ({bus.req1, bus.req0}),
        .prio_i (ptr_q),
        .win_o  (win)
    );

    // Next-state: arbitrate in IDLE, step address/count and capture data in BURST.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        addr_d     = addr_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        cs_d       = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_id_d    = rd_id_q;
        rd_last_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    id_d    = win[1] ? REQ1 : REQ0;
                    addr_d  = win[1] ? bus.addr1 : bus.addr0;
                    cnt_d   = win[1] ? bus.len1 : bus.len0;
                    gnt0_d  = win[0];
                    gnt1_d  = win[1];
                    cs_d    = 1'b1;
                    ptr_d   = win[0];
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                rd_data_d  = bus.rom_data;
                rd_valid_d = 1'b1;
                rd_id_d    = id_q;
                rd_last_d  = (cnt_q == '0);
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    cs_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            addr_q     <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            cs_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            cs_q       <= cs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rom_cs      = cs_q;
    assign bus.rom_read_en = cs_q;
    assign bus.rom_addr    = addr_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_id       = rd_id_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.busy        = (state_q == ST_BURST);

endmodule
